// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first, repeated N times.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit after each copy.
module serial_pattern_tx #(
    parameter int PAT_BITS = 4,
    parameter int REP_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PAT_BITS-1:0] pattern,
    input  logic [REP_BITS-1:0] reps,
    input  logic                abort,
    output logic                o,
    output logic                busy,
    output logic                done
);

    localparam int CW = $clog2(PAT_BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(PAT_BITS - 1);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SEND, PARITY, DONE} state_e;
`else
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
`endif

    state_e              state_q, state_d;
    logic [PAT_BITS-1:0] shreg_q, shreg_d;
    logic [PAT_BITS-1:0] pat_q, pat_d;
    logic [REP_BITS-1:0] rep_q, rep_d;
    logic [CW-1:0]       bit_q, bit_d;
    logic                o_q, o_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wrap;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        bit_d   = bit_q;
        o_d     = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wrap    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    shreg_d = pattern;
                    pat_d   = pattern;
                    rep_d   = (reps == '0) ? REP_BITS'(1) : reps;
                    bit_d   = '0;
                    o_d     = pattern[PAT_BITS-1];
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                busy_d = 1'b1;
                if (bit_q == LAST) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    o_d     = ^pat_q;
                    state_d = PARITY;
`else
                    wrap = 1'b1;
`endif
                end else begin
                    shreg_d = shreg_q << 1;
                    o_d     = shreg_q[PAT_BITS-2];
                    bit_d   = bit_q + CW'(1);
                end
            end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            PARITY: wrap = 1'b1;
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Terminal rep count is tested before decrementing, so rep_q never wraps.
        if (wrap) begin
            if (rep_q > REP_BITS'(1)) begin
                rep_d   = rep_q - REP_BITS'(1);
                shreg_d = pat_q;
                bit_d   = '0;
                o_d     = pat_q[PAT_BITS-1];
                busy_d  = 1'b1;
                state_d = SEND;
            end else begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
        end

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            o_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            pat_q   <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
            o_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            bit_q   <= bit_d;
            o_q     <= o_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o    = o_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Testbench for serial_pattern_tx: table-driven frames checked against a
// per-cycle expected {o,busy,done} queue, plus abort/reset corner cases.
module tb_serial_pattern_tx;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int W = 5;
`else
    localparam int W = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [2:0] reps;
    logic       abort;
    logic       o;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    logic [2:0] q[$];

    typedef struct {
        logic [3:0] pat;
        logic [2:0] reps;
        int         start_at;
        int         frames;
    } vec_t;

    vec_t vecs[6];

    serial_pattern_tx #(.PAT_BITS(4), .REP_BITS(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pattern(pattern),
        .reps   (reps),
        .abort  (abort),
        .o      (o),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2:0] act,
                       input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual{o,busy,done}=%b required=%b",
                     name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: MSB-first bits, reps 0 treated as 1, then DONE, idle.
    task automatic push_frame(input logic [3:0] pat, input logic [2:0] r);
        int n;
        n = (r == 3'd0) ? 1 : int'(r);
        for (int k = 0; k < n; k++) begin
            for (int i = 3; i >= 0; i--)
                q.push_back({pat[i], 2'b10});
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            q.push_back({^pat, 2'b10});
`endif
        end
        q.push_back(3'b001);
        q.push_back(3'b000);
        q.push_back(3'b000);
    endtask

    task automatic drain(input string name, input int start_at,
                         input int abort_at, output int busy_cnt);
        int idx;
        logic [2:0] e;
        idx = 0;
        busy_cnt = 0;
        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            if (busy) busy_cnt++;
            chk($sformatf("%s[%0d]", name, idx), {o, busy, done}, e);
            start = 1'b0;
            abort = 1'b0;
            if (idx == start_at) begin
                start   = 1'b1;
                pattern = ~pattern;
                reps    = 3'd5;
            end
            if (idx == abort_at) abort = 1'b1;
            idx++;
        end
    endtask

    initial begin
        int bc;
        vecs[0] = '{4'b1101, 3'd1, -1, 1};
        vecs[1] = '{4'b1101, 3'd2,  3, 2};
        vecs[2] = '{4'b1011, 3'd0, -1, 1};
        vecs[3] = '{4'b0110, 3'd3,  5, 3};
        vecs[4] = '{4'b1000, 3'd7, -1, 7};
        vecs[5] = '{4'b0001, 3'd1,  1, 1};

        rst     = 1'b1;
        start   = 1'b1;
        pattern = 4'b1101;
        reps    = 3'd1;
        abort   = 1'b0;

        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset_hold", {o, busy, done}, 3'b000);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_reset_idle", {o, busy, done}, 3'b000);
        end

        foreach (vecs[v]) begin
            @(negedge clk);
            pattern = vecs[v].pat;
            reps    = vecs[v].reps;
            start   = 1'b1;
            push_frame(vecs[v].pat, vecs[v].reps);
            drain($sformatf("vec%0d", v), vecs[v].start_at, -1, bc);
            chk_int($sformatf("vec%0d_busy_cycles", v), bc, vecs[v].frames * W);
        end

        // Abort while bit 2 is on the line: next edge goes idle, no done.
        @(negedge clk);
        pattern = 4'b1101;
        reps    = 3'd1;
        start   = 1'b1;
        q.push_back(3'b110);
        q.push_back(3'b110);
        q.push_back(3'b010);
        q.push_back(3'b000);
        q.push_back(3'b000);
        q.push_back(3'b000);
        drain("abort", -1, 2, bc);

        // Abort together with start in IDLE keeps the block idle.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        q.push_back(3'b000);
        q.push_back(3'b000);
        drain("abort_start_idle", -1, -1, bc);

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        @(negedge clk);
        pattern = 4'b1101;
        reps    = 3'd3;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_async_rst", {o, busy, done}, 3'b110);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_immediate", {o, busy, done}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("after_async_rst", {o, busy, done}, 3'b000);
        end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
        begin
            logic [9:0] s;
            s = 10'b1101111011;
            @(negedge clk);
            pattern = 4'b1101;
            reps    = 3'd2;
            start   = 1'b1;
            for (int i = 9; i >= 0; i--) q.push_back({s[i], 2'b10});
            q.push_back(3'b001);
            q.push_back(3'b000);
            drain("parity_literal", -1, -1, bc);
            chk_int("parity_busy_cycles", bc, 10);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
